// File: rtl/pwm_dac_sampler.sv
// pwm_dac_sampler: requests one code per PWM period from an upstream source and plays it out as a duty cycle.
// Compile with PWM_CENTER_EN defined for centre-aligned PWM; the default build is edge-aligned.
module pwm_dac_sampler #(
  parameter int CODE_WIDTH        = 10,
  parameter int CYCLES_PER_SAMPLE = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [CODE_WIDTH-1:0] code_i,
  output logic                  next_sample_o,
  output logic                  pwm_o,
  output logic                  period_start_o,
  output logic                  underrun_o
);

  localparam int CPS   = CYCLES_PER_SAMPLE;
  localparam int CNT_W = $clog2(CPS);
  // Wide enough for both the code and the value CPS itself, so the clamp compare never truncates.
  localparam int EFF_W = (CODE_WIDTH > CNT_W + 1) ? CODE_WIDTH : CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPS - 1);
  localparam logic [CNT_W-1:0] CNT_CAPT = CNT_W'(CPS - 2);
  localparam logic [CNT_W-1:0] CNT_PREQ = CNT_W'(CPS - 4);
  localparam logic [EFF_W-1:0] CPS_E    = EFF_W'(CPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_RUN
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CODE_WIDTH-1:0] shadow_q;
  logic [CODE_WIDTH-1:0] active_q;
  logic                  next_sample_q;
  logic                  pwm_q;
  logic                  period_start_q;
  logic                  underrun_q;

  logic [EFF_W-1:0]      active_ext;
  logic [EFF_W-1:0]      eff;
  logic [EFF_W-1:0]      cnt_ext;
  logic                  pwm_d;
`ifdef PWM_CENTER_EN
  logic [EFF_W-1:0]      start;
`endif

  always_comb begin
    active_ext = EFF_W'(active_q);
    eff        = (active_ext > CPS_E) ? CPS_E : active_ext;
    cnt_ext    = EFF_W'(cnt_q);
`ifdef PWM_CENTER_EN
    start      = (CPS_E - eff) >> 1;
    pwm_d      = (cnt_ext >= start) && (cnt_ext < start + eff);
`else
    pwm_d      = (cnt_ext < eff);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      next_sample_q  <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      next_sample_q  <= 1'b0;
      period_start_q <= 1'b0;
      pwm_q          <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (en_i) begin
            state_q       <= S_FETCH;
            next_sample_q <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_CAPT;
        end
        S_CAPT: begin
          // The first code goes straight to active so the opening period is not lost.
          state_q        <= S_RUN;
          cnt_q          <= '0;
          shadow_q       <= code_i;
          active_q       <= code_i;
          period_start_q <= 1'b1;
        end
        S_RUN: begin
          if (!en_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            if (cnt_q != CNT_LAST) begin
              underrun_q <= 1'b1;
            end
          end else begin
            pwm_q <= pwm_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q          <= '0;
              active_q       <= shadow_q;
              period_start_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
            // Outputs are registered, so the request is raised one count early.
            if (cnt_q == CNT_PREQ) begin
              next_sample_q <= 1'b1;
            end
            if (cnt_q == CNT_CAPT) begin
              shadow_q <= code_i;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign next_sample_o  = next_sample_q;
  assign pwm_o          = pwm_q;
  assign period_start_o = period_start_q;
  assign underrun_o     = underrun_q;

endmodule
